// File: rtl/ds_pass_scheduler.sv
// Command sequencer for the diamond-square terrain datapath: walks corners, then
// alternating diamond/square passes, with a write-acknowledge barrier between passes.
module ds_pass_scheduler #(
  parameter int DIM = 257,
  parameter int CW  = 10,
  parameter int OW  = 18
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [CW-1:0] cmd_x,
  output logic [CW-1:0] cmd_y,
  output logic [1:0]    cmd_phase,
  output logic [CW-2:0] cmd_half,
  output logic [3:0]    cmd_edge,
  output logic          cmd_last,
  input  logic          wb_ack,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_DIAMOND, S_SQUARE, S_DRAIN, S_FINISH
  } state_t;

  localparam logic [CW-1:0] MAXC       = CW'(DIM - 1);
  localparam logic [1:0]    PH_INIT    = 2'd0;
  localparam logic [1:0]    PH_DIAMOND = 2'd1;
  localparam logic [1:0]    PH_SQUARE  = 2'd2;

  state_t        state, state_d;
  state_t        after_drain, after_drain_d;
  logic [CW-1:0] step, step_d;
  logic          row_odd, row_odd_d;
  logic [OW-1:0] outstanding, outstanding_d;

  logic          cmd_valid_d, cmd_last_d;
  logic [CW-1:0] cmd_x_d, cmd_y_d;
  logic [1:0]    cmd_phase_d;
  logic [CW-2:0] cmd_half_d;
  logic [3:0]    cmd_edge_d;
  logic          busy_d, done_d, err_d;

  logic          handshake;
  logic [CW-1:0] h;
  logic [CW-1:0] nx, ny;
  logic          row_end;

  function automatic logic [3:0] edge_flags(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return {x == '0, x == MAXC, y == '0, y == MAXC};
  endfunction

  assign handshake = cmd_valid & cmd_ready;
  assign h         = {1'b0, step[CW-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      after_drain <= S_DIAMOND;
      step        <= MAXC;
      row_odd     <= 1'b0;
      outstanding <= '0;
      cmd_valid   <= 1'b0;
      cmd_x       <= '0;
      cmd_y       <= '0;
      cmd_phase   <= PH_INIT;
      cmd_half    <= '0;
      cmd_edge    <= '0;
      cmd_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_d;
      after_drain <= after_drain_d;
      step        <= step_d;
      row_odd     <= row_odd_d;
      outstanding <= outstanding_d;
      cmd_valid   <= cmd_valid_d;
      cmd_x       <= cmd_x_d;
      cmd_y       <= cmd_y_d;
      cmd_phase   <= cmd_phase_d;
      cmd_half    <= cmd_half_d;
      cmd_edge    <= cmd_edge_d;
      cmd_last    <= cmd_last_d;
      busy        <= busy_d;
      done        <= done_d;
      err         <= err_d;
    end
  end

  always_comb begin
    state_d       = state;
    after_drain_d = after_drain;
    step_d        = step;
    row_odd_d     = row_odd;
    outstanding_d = outstanding;
    cmd_valid_d   = cmd_valid;
    cmd_x_d       = cmd_x;
    cmd_y_d       = cmd_y;
    cmd_phase_d   = cmd_phase;
    cmd_half_d    = cmd_half;
    cmd_edge_d    = cmd_edge;
    cmd_last_d    = cmd_last;
    busy_d        = busy;
    done_d        = done;
    err_d         = err;
    nx            = cmd_x;
    ny            = cmd_y;
    row_end       = 1'b0;

    // A write issued and a write retired in the same cycle cancel out.
    if (handshake && !wb_ack) begin
      outstanding_d = outstanding + OW'(1);
    end else if (!handshake && wb_ack) begin
      if (outstanding == '0) err_d = 1'b1;
      else                   outstanding_d = outstanding - OW'(1);
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d     = S_INIT;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          step_d      = MAXC;
          cmd_valid_d = 1'b1;
          cmd_x_d     = '0;
          cmd_y_d     = '0;
          cmd_phase_d = PH_INIT;
          cmd_half_d  = '0;
          cmd_edge_d  = '0;
          cmd_last_d  = 1'b0;
        end
      end

      S_INIT: begin
        if (handshake) begin
          if (cmd_last) begin
            cmd_valid_d   = 1'b0;
            state_d       = S_DRAIN;
            after_drain_d = S_DIAMOND;
          end else if (cmd_x == '0) begin
            cmd_x_d    = MAXC;
            cmd_last_d = (cmd_y == MAXC);
          end else begin
            cmd_x_d = '0;
            cmd_y_d = MAXC;
          end
        end
      end

      S_DIAMOND: begin
        if (handshake) begin
          if (cmd_last) begin
            cmd_valid_d   = 1'b0;
            state_d       = S_DRAIN;
            after_drain_d = S_SQUARE;
          end else begin
            if (cmd_x == MAXC - h) begin
              nx = h;
              ny = cmd_y + step;
            end else begin
              nx = cmd_x + step;
            end
            cmd_x_d    = nx;
            cmd_y_d    = ny;
            cmd_last_d = (nx == MAXC - h) && (ny == MAXC - h);
          end
        end
      end

      S_SQUARE: begin
        if (handshake) begin
          if (cmd_last) begin
            // h==1 means the finest square pass is complete.
            cmd_valid_d   = 1'b0;
            state_d       = S_DRAIN;
            after_drain_d = (step == CW'(2)) ? S_FINISH : S_DIAMOND;
            step_d        = step >> 1;
          end else begin
            // Odd rows hold the edge midpoints spanning the full width.
            row_end = row_odd ? (cmd_x == MAXC) : (cmd_x == MAXC - h);
            if (row_end) begin
              ny        = cmd_y + h;
              nx        = row_odd ? h : '0;
              row_odd_d = ~row_odd;
            end else begin
              nx = cmd_x + step;
            end
            cmd_x_d    = nx;
            cmd_y_d    = ny;
            cmd_edge_d = edge_flags(nx, ny);
            cmd_last_d = (ny == MAXC) && (nx == MAXC - h);
          end
        end
      end

      S_DRAIN: begin
        if (outstanding == '0) begin
          state_d = after_drain;
          case (after_drain)
            S_DIAMOND: begin
              cmd_valid_d = 1'b1;
              cmd_x_d     = h;
              cmd_y_d     = h;
              cmd_phase_d = PH_DIAMOND;
              cmd_half_d  = h[CW-2:0];
              cmd_edge_d  = '0;
              cmd_last_d  = (h == MAXC - h);
            end
            S_SQUARE: begin
              cmd_valid_d = 1'b1;
              cmd_x_d     = h;
              cmd_y_d     = '0;
              cmd_phase_d = PH_SQUARE;
              cmd_half_d  = h[CW-2:0];
              cmd_edge_d  = edge_flags(h, '0);
              cmd_last_d  = 1'b0;
              row_odd_d   = 1'b0;
            end
            default: begin
              cmd_valid_d = 1'b0;
            end
          endcase
        end
      end

      S_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/ds_pass_scheduler.md
Name: ds_pass_scheduler

Overview:
Sequencer for the diamond-square terrain datapath. After `start`, it emits one command per grid point, in the order the algorithm needs:
- the four corners;
- then alternating diamond and square passes, halving the step after each square pass.

Each command carries the target coordinate, the phase, the half-step and edge flags. A pass does not begin until every write from the previous pass has been acknowledged. This barrier guarantees that later reads see the new heights.

Parameters:
DIM, 257, grid side length; must be 2^N+1 with N≥1.
CW, 10, coordinate width; must satisfy 2^CW > DIM.
OW, 18, outstanding-write counter width; must satisfy 2^OW > DIM*DIM.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse that begins a full generation; ignored while busy
cmd_valid  out  1  command available
cmd_ready  in  1  datapath accepts the command (handshake = cmd_valid & cmd_ready)
cmd_x  out  CW  target column
cmd_y  out  CW  target row
cmd_phase  out  2  0=corner init, 1=diamond, 2=square
cmd_half  out  CW-1  current half-step h (0 during init)
cmd_edge  out  4  {left,right,top,bottom} neighbour missing (square only, else 0)
cmd_last  out  1  this command is the last of its pass
wb_ack  in  1  one-cycle pulse per completed datapath write
busy  out  1  high from accepted start until the final drain completes
done  out  1  high after completion, cleared by the next accepted start
err  out  1  sticky; set when wb_ack arrives with outstanding==0

Behaviour:
- Reset (async):
  - state=IDLE; cmd_valid=0; cmd_x=cmd_y=0; cmd_phase=0; cmd_half=0; cmd_edge=0; cmd_last=0.
  - busy=0; done=0; err=0; outstanding=0; step=DIM-1.
  - Reset mid-pass abandons the pass; no further commands are issued.
- States: IDLE → INIT → DRAIN → DIAMOND → DRAIN → SQUARE → DRAIN → (DIAMOND | FINISH) → IDLE.
- IDLE → INIT:
  - Leave IDLE on start: busy=1, done=0, step=DIM-1, x=y=0.
  - cmd_valid rises the cycle after start.
- INIT: issues (0,0), (DIM-1,0), (0,DIM-1), (DIM-1,DIM-1) with phase 0; cmd_last on the 4th.
- DIAMOND (h=step/2): row-major order.
  - y = h, h+step, …, DIM-1-h.
  - x over the same set.
- SQUARE: y = 0, h, 2h, …, DIM-1.
  - Rows with (y/h) even: x = h, h+step, …, DIM-1-h.
  - Rows with (y/h) odd: x = 0, step, …, DIM-1.
  - Edge flags: left = (x==0), right = (x==DIM-1), top = (y==0), bottom = (y==DIM-1).
- Command registers:
  - Advance only on the handshake.
  - While cmd_valid=1 and cmd_ready=0, all cmd_* outputs hold stable.
  - Back-to-back issue: one command per cycle when cmd_ready is held high.
- After the handshake with cmd_last=1: cmd_valid=0 next cycle, enter DRAIN.
- DRAIN:
  - Waits until outstanding==0.
  - Exits on the next cycle to the next pass, with cmd_valid=1 in that cycle.
- Step update:
  - After a square pass, step←step>>1.
  - If the completed square pass had h==1 → FINISH instead of DIAMOND.
- FINISH: one cycle, then busy=0, done=1, state=IDLE.
- Outstanding counter:
  - +1 on handshake, −1 on wb_ack; unchanged when both occur in the same cycle.
  - wb_ack at 0: counter stays 0 and err=1.
  - err clears only on reset.
- Total commands per generation = DIM*DIM. Passes per generation = 1 + 2·log2(DIM−1).
- start while busy: ignored, with no effect on state, counters or err.
- No wrap-around: x and y never exceed DIM−1. Coordinate arithmetic is unsigned CW bits.

Test Plan:
- DIM=5, cmd_ready=1, wb_ack returned 2 cycles after each handshake → command sequence (x,y,phase):
  - init (0,0),(4,0),(0,4),(4,4);
  - diamond (2,2), h=2;
  - square (2,0),(0,2),(4,2),(2,4);
  - diamond (1,1),(3,1),(1,3),(3,3);
  - square 12 points in the order given above;
  - 25 commands total, done=1, busy=0.
- DIM=5, square pass h=2: edge flags are (2,0)→0010, (0,2)→1000, (4,2)→0100, (2,4)→0001.
- Barrier: withhold wb_ack for the 4 init commands → cmd_valid stays 0 in DRAIN. After the 4th ack, (2,2) is presented one cycle later.
- Backpressure: deassert cmd_ready for 5 cycles mid-pass → cmd_x/y/phase/edge stable throughout. No command skipped or duplicated.
- Same-cycle handshake and wb_ack leave outstanding unchanged. Extra wb_ack at outstanding=0 → err=1, counter remains 0.
- Async reset asserted mid-square pass → all outputs take their reset values without a clock edge. A later start regenerates from (0,0) with the full 25-command sequence for DIM=5.
